// File: rtl/demux32_pkg.sv
// Shared constants, types and helpers for the 32-lane dispatch demux.
// Imported by demux_lane and demux32_dispatch.
package demux32_pkg;

    localparam int LANES = 32;
    localparam int SEL_W = 5;
    localparam int OCC_W = 6;

    typedef logic [SEL_W-1:0] sel_t;

    // Number of set bits in a lane vector; 32 fits in OCC_W bits.
    function automatic logic [OCC_W-1:0] popcount(
        input logic [LANES-1:0] v
    );
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: an N-bit payload register and a data-held flag.
// Load wins over drain so a same-cycle reload keeps the lane full.
module demux_lane #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic [N-1:0] i_data,
    output logic [N-1:0] o_data,
    output logic         o_valid
);

    logic [N-1:0] r_data;
    logic         r_valid;

    // Payload register; keeps its last value after a drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    // Valid flag: set on load, cleared on drain unless reloaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux32_dispatch.sv
// 1-to-32 dispatch demux with per-lane valid/ready and occupancy count.
// Define DEMUX32_AUTOINC_EN to replace in_select by a round-robin pointer.
module demux32_dispatch
    import demux32_pkg::*;
#(
    parameter int N = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            in_data,
    input  sel_t                    in_select,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [31:0][N-1:0]      out_data,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic [OCC_W-1:0]        occupancy
);

    localparam logic [LANES-1:0] ONE_HOT0 = LANES'(1);

    sel_t               w_dest;
    logic               w_accept;
    logic               w_inc;
    logic [LANES-1:0]   w_load;
    logic [LANES-1:0]   w_drain;
    logic [OCC_W-1:0]   w_dec;
    logic [OCC_W-1:0]   r_occ;

`ifdef DEMUX32_AUTOINC_EN
    sel_t r_ptr;
    logic w_unused_sel;

    // Round-robin destination pointer; only an accept advances it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= r_ptr + sel_t'(1);
        end
    end

    assign w_dest       = r_ptr;
    assign w_unused_sel = ^in_select;
`else
    assign w_dest = in_select;
`endif

    assign in_ready = !out_valid[w_dest] | out_ready[w_dest];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? (ONE_HOT0 << w_dest) : '0;
    assign w_drain  = out_valid & out_ready;
    assign w_inc    = w_accept & !out_valid[w_dest];
    assign w_dec    = popcount(w_drain & ~w_load);

    // Occupancy tracks popcount(out_valid) incrementally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_inc) - w_dec;
        end
    end

    assign occupancy = r_occ;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        demux_lane #(
            .N (N)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_drain (w_drain[g]),
            .i_data  (in_data),
            .o_data  (out_data[g]),
            .o_valid (out_valid[g])
        );
    end

endmodule

// File: tb/tb_demux32_dispatch.sv
// Scoreboard bench for demux32_dispatch (select or auto-increment build).
// Expected lane state is queued at drive time and compared after the edge.
module tb_demux32_dispatch;

    localparam int N = 8;

`ifdef DEMUX32_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic [31:0]         valid;
        logic [31:0][N-1:0]  data;
        logic [5:0]          occ;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [N-1:0]        in_data;
    logic [4:0]          in_select;
    logic                in_valid;
    logic                in_ready;
    logic [31:0][N-1:0]  out_data;
    logic [31:0]         out_valid;
    logic [31:0]         out_ready;
    logic [5:0]          occupancy;

    logic [31:0]         m_valid;
    logic [31:0][N-1:0]  m_data;
    logic [4:0]          m_ptr;
    exp_t                sbq[$];

    int n_pass;
    int n_total;

    demux32_dispatch #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = '0;
        m_data  = '0;
        m_ptr   = '0;
    endtask

    // One clock of stimulus; the model result is queued then checked.
    task automatic cycle(input logic v, input logic [4:0] sel,
                         input logic [N-1:0] dat, input logic [31:0] ordy);
        logic [4:0] dst;
        logic       rdy;
        exp_t       e;
        in_valid  = v;
        in_select = sel;
        in_data   = dat;
        out_ready = ordy;
        dst = AUTO ? m_ptr : sel;
        rdy = !m_valid[dst] | ordy[dst];
        #1;
        n_total++;
        if (in_ready !== rdy)
            $display("FAIL in_ready: got %b want %b", in_ready, rdy);
        else
            n_pass++;
        e.valid = m_valid & ~ordy;
        e.data  = m_data;
        if (v && rdy) begin
            e.valid[dst] = 1'b1;
            e.data[dst]  = dat;
            m_ptr = m_ptr + 5'd1;
        end
        e.occ   = 6'($countones(e.valid));
        m_valid = e.valid;
        m_data  = e.data;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        n_total++;
        if (out_valid !== e.valid)
            $display("FAIL out_valid: got %h want %h", out_valid, e.valid);
        else
            n_pass++;
        n_total++;
        if (out_data !== e.data)
            $display("FAIL out_data: got %h want %h", out_data, e.data);
        else
            n_pass++;
        n_total++;
        if (occupancy !== e.occ)
            $display("FAIL occupancy: got %0d want %0d", occupancy, e.occ);
        else
            n_pass++;
        in_valid  = 1'b0;
        out_ready = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_select = '0;
        in_data = '0;
        out_ready = '0;
        model_reset();
        #12;
        n_total++;
        if (out_valid !== 32'h0 || occupancy !== 6'd0 || in_ready !== 1'b1)
            $display("FAIL reset: valid %h occ %0d rdy %b want 0 0 1",
                     out_valid, occupancy, in_ready);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_load();
        cycle(1'b1, 5'd5, 8'h01, 32'h0);
        n_total++;
        if (out_valid !== 32'h0000_0020 || out_data[5] !== 8'h01 ||
            occupancy !== 6'd1)
            $display("FAIL single_load: valid %h d5 %h occ %0d want 20 01 1",
                     out_valid, out_data[5], occupancy);
        else
            n_pass++;
    endtask

    task automatic test_stall();
        cycle(1'b1, 5'd5, 8'hAA, 32'h0);
        n_total++;
        if (out_data[5] !== 8'h01 || occupancy !== 6'd1)
            $display("FAIL stall: d5 %h occ %0d want 01 1",
                     out_data[5], occupancy);
        else
            n_pass++;
        cycle(1'b1, 5'd6, 8'h66, 32'h0);
        n_total++;
        if (out_valid !== 32'h0000_0060 || out_data[6] !== 8'h66)
            $display("FAIL stall_other: valid %h d6 %h want 60 66",
                     out_valid, out_data[6]);
        else
            n_pass++;
    endtask

    task automatic test_drain_reload();
        cycle(1'b1, 5'd3, 8'h33, 32'h0);
        cycle(1'b1, 5'd3, 8'h3C, 32'h0000_0008);
        n_total++;
        if (out_valid[3] !== 1'b1 || out_data[3] !== 8'h3C ||
            occupancy !== 6'd3)
            $display("FAIL drain_reload: v3 %b d3 %h occ %0d want 1 3c 3",
                     out_valid[3], out_data[3], occupancy);
        else
            n_pass++;
    endtask

    task automatic test_fill_all();
        cycle(1'b0, 5'd0, 8'h00, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 5'(i), 8'(8'h80 + i), 32'h0);
        end
        n_total++;
        if (occupancy !== 6'd32 || out_valid !== 32'hFFFF_FFFF)
            $display("FAIL fill_all: occ %0d valid %h want 32 ffffffff",
                     occupancy, out_valid);
        else
            n_pass++;
        cycle(1'b0, 5'd0, 8'h00, 32'hFFFF_FFFF);
        n_total++;
        if (occupancy !== 6'd0 || out_valid !== 32'h0 ||
            out_data[7] !== 8'h87)
            $display("FAIL drain_all: occ %0d valid %h d7 %h want 0 0 87",
                     occupancy, out_valid, out_data[7]);
        else
            n_pass++;
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 5'd0, 8'h10, 32'h0);
        cycle(1'b1, 5'd9, 8'h19, 32'h0);
        cycle(1'b1, 5'd17, 8'h27, 32'h0);
        cycle(1'b1, 5'd31, 8'h3F, 32'h0);
        cycle(1'b0, 5'd0, 8'h00, 32'h0000_0002);
        in_valid  = 1'b1;
        in_select = 5'd4;
        in_data   = 8'h44;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 32'h0 || out_data !== '0 || occupancy !== 6'd0)
            $display("FAIL async_reset: valid %h occ %0d data %h want zeros",
                     out_valid, occupancy, out_data);
        else
            n_pass++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        cycle(1'b1, 5'd2, 8'h22, 32'h0);
        n_total++;
        if (occupancy !== 6'd1 || out_valid !== (AUTO ? 32'h1 : 32'h4))
            $display("FAIL after_reset: occ %0d valid %h want 1",
                     occupancy, out_valid);
        else
            n_pass++;
    endtask

    task automatic test_autoinc();
        logic [N-1:0] dat;
        cycle(1'b0, 5'd0, 8'h00, 32'hFFFF_FFFF);
        cycle(1'b1, 5'd9, 8'h51, 32'h0);
        cycle(1'b1, 5'd9, 8'h52, 32'h0);
        cycle(1'b0, 5'd0, 8'h00, 32'hFFFF_FFFF);
        for (int i = 0; i < 33; i++) begin
            dat = 8'(8'hC0 + i);
            cycle(1'b1, 5'($urandom_range(0, 31)), dat, 32'hFFFF_FFFF);
            n_total++;
            if (out_valid !== (32'h1 << ((i + 2) % 32)) ||
                out_data[(i + 2) % 32] !== dat)
                $display("FAIL autoinc[%0d]: valid %h want lane %0d",
                         i, out_valid, (i + 2) % 32);
            else
                n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
`ifdef DEMUX32_AUTOINC_EN
        test_autoinc();
`else
        test_single_load();
        test_stall();
        test_drain_reload();
        test_fill_all();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
